key_event_ctrl: RTL and testbench



---
 rtl/key_evt_pkg.sv | 17 +
 rtl/key_evt_fifo.sv | 42 ++++
 rtl/key_event_ctrl.sv | 134 +++++++++++++
 tb/tb_key_event_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// Shared constants for the key event sequencer: event types, FSM encodings, FIFO entry layout.
package key_evt_pkg;
   localparam logic [1:0] EV_SHORT  = 2'd0;
   localparam logic [1:0] EV_LONG   = 2'd1;
   localparam logic [1:0] EV_REPEAT = 2'd2;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PRESSED = 2'd1;
   localparam logic [1:0] ST_HELD    = 2'd2;

   localparam int EV_W = 5;

   typedef struct packed {
      logic [2:0] code;
      logic [1:0] typ;
   } ev_entry_t;
endpackage

// File: rtl/key_evt_fifo.sv
// First-word fall-through FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module key_evt_fifo
   import key_evt_pkg::*;
#(
   parameter int W  = EV_W,
   parameter int AW = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   logic [W-1:0] mem [2**AW];
   logic [AW:0]  wr_ptr, rd_ptr;
   logic         do_push, do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   // Head is forced to zero when empty so the outputs read 0 out of reset.
   assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/key_event_ctrl.sv
// Classifies debounced key presses into SHORT/LONG/REPEAT events and queues them for the menu FSM.
// Auto-repeat in HELD is built only when KEY_EVT_AUTOREPEAT_EN is defined.
module key_event_ctrl
   import key_evt_pkg::*;
#(
   parameter int TICK_DIV = 50000,
   parameter int LONG_MS  = 1000,
   parameter int REP_MS   = 200,
   parameter int FIFO_AW  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pos_tick,
   input  logic       neg_tick,
   input  logic [2:0] kcode,
   input  logic       ev_ready,
   input  logic       ovf_clr,
   output logic       ev_valid,
   output logic [2:0] ev_code,
   output logic [1:0] ev_type,
   output logic       overflow,
   output logic       busy
);
   localparam int PS_W = $clog2(TICK_DIV + 1);
   localparam int MS_W = $clog2(((LONG_MS > REP_MS) ? LONG_MS : REP_MS) + 1);
   localparam logic [PS_W-1:0] PS_LAST   = PS_W'(TICK_DIV - 1);
   localparam logic [MS_W-1:0] LONG_LAST = MS_W'(LONG_MS - 1);
`ifdef KEY_EVT_AUTOREPEAT_EN
   localparam logic [MS_W-1:0] REP_LAST  = MS_W'(REP_MS - 1);
`endif

   logic [1:0]      state;
   logic [PS_W-1:0] presc;
   logic [MS_W-1:0] ms_cnt;
   logic [2:0]      code_q;
   logic            ms_wrap, long_hit, rep_hit;
   logic            push, pop, full, empty;
   logic [1:0]      push_type;
   ev_entry_t       push_ent, head;

   // Threshold is hit in the last cycle before the ms counter would reach its limit.
   assign ms_wrap  = (presc == PS_LAST);
   assign long_hit = ms_wrap && (ms_cnt == LONG_LAST);
`ifdef KEY_EVT_AUTOREPEAT_EN
   assign rep_hit  = ms_wrap && (ms_cnt == REP_LAST);
`else
   assign rep_hit  = 1'b0;
`endif

   always_comb begin
      push      = 1'b0;
      push_type = EV_SHORT;
      case (state)
         ST_PRESSED: begin
            if (neg_tick) begin
               push = 1'b1;
            end else if (long_hit) begin
               push      = 1'b1;
               push_type = EV_LONG;
            end
         end
         ST_HELD: begin
            if (!neg_tick && rep_hit) begin
               push      = 1'b1;
               push_type = EV_REPEAT;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         presc  <= '0;
         ms_cnt <= '0;
         code_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pos_tick) begin
                  code_q <= kcode;
                  presc  <= '0;
                  ms_cnt <= '0;
                  state  <= ST_PRESSED;
               end
            end
            ST_PRESSED, ST_HELD: begin
               if (neg_tick) begin
                  state <= ST_IDLE;
               end else if ((state == ST_PRESSED && long_hit) || (state == ST_HELD && rep_hit)) begin
                  presc  <= '0;
                  ms_cnt <= '0;
                  state  <= ST_HELD;
               end else if (ms_wrap) begin
                  presc  <= '0;
                  ms_cnt <= ms_cnt + 1'b1;
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign pop = ev_valid && ev_ready;

   // A dropped push wins over a same-cycle clear so the loss is never hidden.
   always_ff @(posedge clk) begin
      if (reset)                      overflow <= 1'b0;
      else if (push && full && !pop)  overflow <= 1'b1;
      else if (ovf_clr)               overflow <= 1'b0;
   end

   assign push_ent.code = code_q;
   assign push_ent.typ  = push_type;

   key_evt_fifo #(.W(EV_W), .AW(FIFO_AW)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (push_ent),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   assign ev_valid = !empty;
   assign ev_code  = head.code;
   assign ev_type  = head.typ;
   assign busy     = (state != ST_IDLE);
endmodule

// File: tb/tb_key_event_ctrl.sv
// Scoreboard bench for key_event_ctrl at TICK_DIV=50, LONG_MS=10, REP_MS=4 (LONG at 500 cycles, REPEAT every 200).
module tb_key_event_ctrl;
   import key_evt_pkg::*;

   logic       clk = 1'b0, reset = 1'b1;
   logic       pos_tick = 1'b0, neg_tick = 1'b0, ev_ready = 1'b0, ovf_clr = 1'b0;
   logic [2:0] kcode = '0;
   logic       ev_valid, overflow, busy;
   logic [2:0] ev_code;
   logic [1:0] ev_type;

   int cyc = 0, n_cmp = 0, n_err = 0;

   typedef struct {
      int         cyc;
      logic [2:0] code;
      logic [1:0] typ;
   } exp_t;
   exp_t sb[$];

   key_event_ctrl #(.TICK_DIV(50), .LONG_MS(10), .REP_MS(4), .FIFO_AW(2)) dut (
      .clk(clk), .reset(reset), .pos_tick(pos_tick), .neg_tick(neg_tick), .kcode(kcode),
      .ev_ready(ev_ready), .ovf_clr(ovf_clr), .ev_valid(ev_valid), .ev_code(ev_code),
      .ev_type(ev_type), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // Every accepted head event is checked against the oldest expectation (cycle 0 = don't care).
   always @(negedge clk) begin
      if (!reset && ev_valid && ev_ready) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event cyc=%0d code=%0d type=%0d", cyc, ev_code, ev_type);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (ev_code !== e.code || ev_type !== e.typ || (e.cyc != 0 && cyc != e.cyc)) begin
               n_err++;
               $display("FAIL event got cyc=%0d code=%0d type=%0d exp cyc=%0d code=%0d type=%0d",
                        cyc, ev_code, ev_type, e.cyc, e.code, e.typ);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input int c);
      while (cyc < c) step();
   endtask

   task automatic expect_ev(input int c, input logic [2:0] code, input logic [1:0] typ);
      exp_t e;
      e.cyc = c; e.code = code; e.typ = typ;
      sb.push_back(e);
   endtask

   task automatic pulse_pos(input logic [2:0] code);
      pos_tick = 1'b1; kcode = code;
      step();
      pos_tick = 1'b0; kcode = '0;
   endtask

   task automatic pulse_neg();
      neg_tick = 1'b1;
      step();
      neg_tick = 1'b0;
   endtask

   task automatic press(input logic [2:0] code);
      pulse_pos(code);
      repeat (4) step();
      pulse_neg();
      step();
   endtask

   task automatic do_reset();
      reset = 1'b1; ev_ready = 1'b0; ovf_clr = 1'b0;
      step(); step();
      reset = 1'b0;
      sb.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      n_cmp++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL reset_ev_valid got=%b exp=0", ev_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      n_cmp++; if ({ev_code, ev_type} !== 5'b0) begin n_err++; $display("FAIL reset_head got=%b exp=0", {ev_code, ev_type}); end
      reset = 1'b0;
   endtask

   task automatic test_short();
      do_reset(); ev_ready = 1'b1;
      goto(100); pulse_pos(3'd3);
      goto(300);
      n_cmp++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL short_early got=%b exp=0", ev_valid); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL short_busy got=%b exp=1", busy); end
      expect_ev(301, 3'd3, EV_SHORT);
      pulse_neg();
      goto(320);
      n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL short_pending got=%0d exp=0", sb.size()); end
      n_cmp++; if (ev_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL short_idle got=%b%b exp=00", ev_valid, busy); end
   endtask

   task automatic test_long_repeat();
      do_reset(); ev_ready = 1'b1;
      goto(100); pulse_pos(3'd5);
      expect_ev(601, 3'd5, EV_LONG);
`ifdef KEY_EVT_AUTOREPEAT_EN
      expect_ev(801, 3'd5, EV_REPEAT);
      expect_ev(1001, 3'd5, EV_REPEAT);
`endif
      goto(650);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL held_busy got=%b exp=1", busy); end
      goto(1100); pulse_neg();
      goto(1300);
      n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL long_pending got=%0d exp=0", sb.size()); end
      n_cmp++; if (ev_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL long_idle got=%b%b exp=00", ev_valid, busy); end
   endtask

   task automatic test_boundary();
      do_reset(); ev_ready = 1'b1;
      goto(100); pulse_pos(3'd6);
      goto(600);
      expect_ev(601, 3'd6, EV_SHORT);
      pulse_neg();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL boundary_idle got=%b exp=0", busy); end
      goto(700);
      n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL boundary_pending got=%0d exp=0", sb.size()); end
   endtask

   task automatic test_ignored();
      do_reset(); ev_ready = 1'b1;
      goto(100); pulse_pos(3'd4);
      goto(150); pulse_pos(3'd2);
      goto(200);
      expect_ev(201, 3'd4, EV_SHORT);
      pulse_neg();
      goto(300); pulse_neg();
      goto(320);
      n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL ignored_pending got=%0d exp=0", sb.size()); end
      n_cmp++; if (ev_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL ignored_idle got=%b%b exp=00", ev_valid, busy); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         pulse_pos(3'(i));
         repeat (4) step();
         pulse_neg();
         if (i == 4) begin
            n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got=%b exp=0", overflow); end
         end
         if (i == 5) begin
            n_cmp++; if (overflow !== 1'b1 || ev_valid !== 1'b1) begin n_err++; $display("FAIL ovf_set got=%b%b exp=11", overflow, ev_valid); end
         end
         step();
      end
      for (int i = 1; i <= 4; i++) expect_ev(0, 3'(i), EV_SHORT);
      ev_ready = 1'b1; repeat (8) step(); ev_ready = 1'b0;
      n_cmp++; if (sb.size() != 0 || ev_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drain got=%0d/%b exp=0/0", sb.size(), ev_valid); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
      ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr got=%b exp=0", overflow); end

      // Full FIFO: push with a simultaneous pop must be accepted.
      for (int i = 1; i <= 4; i++) press(3'(i));
      for (int i = 1; i <= 5; i++) expect_ev(0, 3'(i), EV_SHORT);
      pulse_pos(3'd5); repeat (4) step();
      neg_tick = 1'b1; ev_ready = 1'b1; step(); neg_tick = 1'b0; ev_ready = 1'b0;
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_pop_push got=%b exp=0", overflow); end
      ev_ready = 1'b1; repeat (8) step(); ev_ready = 1'b0;
      n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL full_pop_drain got=%0d exp=0", sb.size()); end

      // Drop coinciding with a clear leaves the flag set.
      for (int i = 1; i <= 4; i++) press(3'(i + 2));
      pulse_pos(3'd7); repeat (4) step();
      neg_tick = 1'b1; ovf_clr = 1'b1; step(); neg_tick = 1'b0; ovf_clr = 1'b0;
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_clr_race got=%b exp=1", overflow); end
      for (int i = 1; i <= 4; i++) expect_ev(0, 3'(i + 2), EV_SHORT);
      ev_ready = 1'b1; repeat (8) step();
      n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL race_drain got=%0d exp=0", sb.size()); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      press(3'd1);
      pulse_pos(3'd3);
      repeat (505) step();
      n_cmp++; if (busy !== 1'b1 || ev_valid !== 1'b1) begin n_err++; $display("FAIL mid_held got=%b%b exp=11", busy, ev_valid); end
      reset = 1'b1; step(); reset = 1'b0;
      n_cmp++; if (ev_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL mid_reset got=%b%b%b exp=000", ev_valid, busy, overflow); end
      ev_ready = 1'b1;
      pulse_neg();
      repeat (20) step();
      n_cmp++; if (sb.size() != 0 || ev_valid !== 1'b0) begin n_err++; $display("FAIL mid_release got=%0d/%b exp=0/0", sb.size(), ev_valid); end
   endtask

   initial begin
      test_reset();
      test_short();
      test_long_repeat();
      test_boundary();
      test_ignored();
      test_overflow();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
